reg_rename_mng: RTL and testbench

- Parametrised successor to the single-port register manager.
- Renames up to RENAME_W instructions per cycle: speculative RAT lookup, physical-register allocation from a circular free list, and intra-group dependency bypass.
- Frees old mappings at commit and restores speculative state after a pipeline flush.
- Sits between decoder and ROB/issue: decoder drives the rename lanes; ROB drives the commit lanes and flush.

---
 rtl/reg_mng_pkg.sv | 27 ++
 rtl/reg_free_list.sv | 83 ++++++++
 rtl/reg_rename_mng.sv | 232 +++++++++++++++++++++++
 tb/tb_reg_rename_mng.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_mng_pkg.sv
// Shared types, free-list depth, FSM encoding and pointer helper for the
// multi-lane register rename manager.
package reg_mng_pkg;

    localparam int ARCH_REGS_DEF = 32;
    localparam int PHYS_REGS_DEF = 64;
    localparam int FL_DEPTH      = PHYS_REGS_DEF - ARCH_REGS_DEF;

    typedef logic [$clog2(ARCH_REGS_DEF)-1:0] areg_t;
    typedef logic [$clog2(PHYS_REGS_DEF)-1:0] preg_t;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } state_e;

    // Distance a - b on pointers of width w; the extra wrap bit makes a full
    // list (distance == depth) distinct from an empty one (distance == 0).
    function automatic logic [31:0] ptr_dist(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input int unsigned w);
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        return (a - b) & mask;
    endfunction

endpackage

// File: rtl/reg_free_list.sv
// Circular physical-register free list: speculative head for allocation,
// commit head for recovery, tail for frees, with multi-pop/multi-push.
module reg_free_list
    import reg_mng_pkg::*;
#(
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64,
    parameter int RENAME_W  = 2,
    parameter int PW        = $clog2(PHYS_REGS),
    parameter int PTRW      = $clog2(PHYS_REGS - ARCH_REGS) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pop_en,
    input  logic [PTRW-1:0]        pop_cnt,
    input  logic [RENAME_W-1:0]    push_valid,
    input  logic [RENAME_W*PW-1:0] push_data,
    input  logic                   restore,
    output logic [RENAME_W*PW-1:0] peek_data,
    output logic [PTRW-1:0]        free_cnt
);

    localparam int FL_N = PHYS_REGS - ARCH_REGS;
    localparam int IW   = PTRW - 1;

    logic [PW-1:0]   mem_q [FL_N];
    logic [PW-1:0]   mem_d [FL_N];
    logic [PTRW-1:0] spec_head_q, spec_head_d;
    logic [PTRW-1:0] cmt_head_q, cmt_head_d;
    logic [PTRW-1:0] tail_q, tail_d;

    // Entry k is the k-th register that would be handed out this cycle.
    always_comb begin : c_peek
        logic [PTRW-1:0] p;
        p         = '0;
        peek_data = '0;
        for (int k = 0; k < RENAME_W; k++) begin
            p = spec_head_q + PTRW'(k);
            peek_data[k*PW +: PW] = mem_q[p[IW-1:0]];
        end
    end

    always_comb begin : c_push
        logic [PTRW-1:0] wp;
        mem_d = mem_q;
        wp    = tail_q;
        for (int k = 0; k < RENAME_W; k++) begin
            if (push_valid[k]) begin
                mem_d[wp[IW-1:0]] = push_data[k*PW +: PW];
                wp = wp + PTRW'(1);
            end
        end
        tail_d     = wp;
        cmt_head_d = cmt_head_q + (wp - tail_q);
    end

    always_comb begin
        spec_head_d = spec_head_q;
        if (restore) begin
            spec_head_d = cmt_head_q;
        end else if (pop_en) begin
            spec_head_d = spec_head_q + pop_cnt;
        end
        free_cnt = PTRW'(ptr_dist(32'(tail_q), 32'(spec_head_q), PTRW));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FL_N; i++) begin
                mem_q[i] <= PW'(ARCH_REGS + i);
            end
            spec_head_q <= '0;
            cmt_head_q  <= '0;
            tail_q      <= PTRW'(FL_N);
        end else begin
            mem_q       <= mem_d;
            spec_head_q <= spec_head_d;
            cmt_head_q  <= cmt_head_d;
            tail_q      <= tail_d;
        end
    end

endmodule

// File: rtl/reg_rename_mng.sv
// Multi-lane register rename manager: speculative/committed RATs, free list,
// flush recovery. Optional ready table enabled by REG_MNG_BUSY_TABLE_EN.
//
// state   | meaning
// RUN     | rename groups accepted, commits applied
// RECOVER | one cycle: spec RAT <= committed RAT, spec head <= commit head
module reg_rename_mng
    import reg_mng_pkg::*;
#(
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64,
    parameter int RENAME_W  = 2,
    parameter int AW        = $clog2(ARCH_REGS),
    parameter int PW        = $clog2(PHYS_REGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [RENAME_W-1:0]    ren_valid,
    output logic                   ren_ready,
    input  logic [RENAME_W*AW-1:0] ren_rs1,
    input  logic [RENAME_W*AW-1:0] ren_rs2,
    input  logic [RENAME_W*AW-1:0] ren_rd,
    input  logic [RENAME_W-1:0]    ren_rd_we,
    output logic [RENAME_W*PW-1:0] ren_prs1,
    output logic [RENAME_W*PW-1:0] ren_prs2,
    output logic [RENAME_W*PW-1:0] ren_prd,
    output logic [RENAME_W*PW-1:0] ren_old_prd,
    input  logic [RENAME_W-1:0]    cmt_valid,
    input  logic [RENAME_W-1:0]    cmt_rd_we,
    input  logic [RENAME_W*AW-1:0] cmt_rd,
    input  logic [RENAME_W*PW-1:0] cmt_prd,
    input  logic [RENAME_W*PW-1:0] cmt_old_prd,
    input  logic                   flush,
`ifdef REG_MNG_BUSY_TABLE_EN
    input  logic [RENAME_W-1:0]    wb_valid,
    input  logic [RENAME_W*PW-1:0] wb_prd,
    output logic [RENAME_W-1:0]    ren_rs1_rdy,
    output logic [RENAME_W-1:0]    ren_rs2_rdy,
`endif
    output logic                   busy
);

    localparam int FL_N = PHYS_REGS - ARCH_REGS;
    localparam int PTRW = $clog2(FL_N) + 1;

    if ((FL_N < 2) || ((FL_N & (FL_N - 1)) != 0)) begin : g_fl_chk
        $error("PHYS_REGS - ARCH_REGS must be a power of two");
    end

    state_e          state_q, state_d;
    logic [PW-1:0]   spec_rat_q [ARCH_REGS];
    logic [PW-1:0]   spec_rat_d [ARCH_REGS];
    logic [PW-1:0]   crat_q     [ARCH_REGS];
    logic [PW-1:0]   crat_d     [ARCH_REGS];

    logic [AW-1:0]   rs1_a [RENAME_W];
    logic [AW-1:0]   rs2_a [RENAME_W];
    logic [AW-1:0]   rd_a  [RENAME_W];
    logic [PW-1:0]   prs1_a [RENAME_W];
    logic [PW-1:0]   prs2_a [RENAME_W];
    logic [PW-1:0]   prd_a  [RENAME_W];
    logic [PW-1:0]   old_a  [RENAME_W];
    logic [PW-1:0]   peek_a [RENAME_W];
    logic [RENAME_W-1:0]    we_eff;
    logic [RENAME_W-1:0]    cmt_we;
    logic [RENAME_W*PW-1:0] peek_flat;
    logic [PTRW-1:0] free_cnt;
    logic [PTRW-1:0] pop_cnt;
    logic            accept;
    logic            restore;

    // Lane k takes the n-th peeked entry, n = allocating lanes below k; later
    // lanes see earlier same-group destinations instead of the RAT.
    always_comb begin : c_rename
        int n;
        n = 0;
        for (int k = 0; k < RENAME_W; k++) begin
            rs1_a[k]  = ren_rs1[k*AW +: AW];
            rs2_a[k]  = ren_rs2[k*AW +: AW];
            rd_a[k]   = ren_rd[k*AW +: AW];
            peek_a[k] = peek_flat[k*PW +: PW];
        end
        for (int k = 0; k < RENAME_W; k++) begin
            we_eff[k] = ren_valid[k] && ren_rd_we[k] && (rd_a[k] != '0);
            prd_a[k]  = '0;
            for (int j = 0; j < RENAME_W; j++) begin
                if (we_eff[k] && (n == j)) prd_a[k] = peek_a[j];
            end
            if (we_eff[k]) n++;
            prs1_a[k] = (rs1_a[k] == '0) ? '0 : spec_rat_q[rs1_a[k]];
            prs2_a[k] = (rs2_a[k] == '0) ? '0 : spec_rat_q[rs2_a[k]];
            old_a[k]  = (rd_a[k]  == '0) ? '0 : spec_rat_q[rd_a[k]];
            for (int j = 0; j < k; j++) begin
                if (we_eff[j] && (rd_a[j] == rs1_a[k])) prs1_a[k] = prd_a[j];
                if (we_eff[j] && (rd_a[j] == rs2_a[k])) prs2_a[k] = prd_a[j];
                if (we_eff[j] && (rd_a[j] == rd_a[k]))  old_a[k]  = prd_a[j];
            end
        end
        pop_cnt = PTRW'(n);
    end

    always_comb begin
        ren_prs1    = '0;
        ren_prs2    = '0;
        ren_prd     = '0;
        ren_old_prd = '0;
        for (int k = 0; k < RENAME_W; k++) begin
            ren_prs1[k*PW +: PW]    = prs1_a[k];
            ren_prs2[k*PW +: PW]    = prs2_a[k];
            ren_prd[k*PW +: PW]     = prd_a[k];
            ren_old_prd[k*PW +: PW] = old_a[k];
        end
    end

    assign accept  = ren_valid[0] && ren_ready;
    assign restore = (state_q == RECOVER);

    always_comb begin
        crat_d = crat_q;
        for (int k = 0; k < RENAME_W; k++) begin
            cmt_we[k] = (state_q == RUN) && cmt_valid[k] && cmt_rd_we[k]
                        && (cmt_rd[k*AW +: AW] != '0);
            if (cmt_we[k]) crat_d[cmt_rd[k*AW +: AW]] = cmt_prd[k*PW +: PW];
        end
    end

    always_comb begin
        spec_rat_d = spec_rat_q;
        if (state_q == RECOVER) begin
            spec_rat_d = crat_q;
        end else if (accept) begin
            for (int k = 0; k < RENAME_W; k++) begin
                if (we_eff[k]) spec_rat_d[rd_a[k]] = prd_a[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                spec_rat_q[i] <= PW'(i);
                crat_q[i]     <= PW'(i);
            end
        end else begin
            spec_rat_q <= spec_rat_d;
            crat_q     <= crat_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (flush) state_d = RECOVER;
            RECOVER: state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        busy      = (state_q == RECOVER);
        ren_ready = (state_q == RUN) && !flush && (free_cnt >= PTRW'(RENAME_W));
    end

    reg_free_list #(
        .ARCH_REGS (ARCH_REGS),
        .PHYS_REGS (PHYS_REGS),
        .RENAME_W  (RENAME_W),
        .PW        (PW),
        .PTRW      (PTRW)
    ) u_free_list (
        .clk        (clk),
        .rst_n      (rst_n),
        .pop_en     (accept),
        .pop_cnt    (pop_cnt),
        .push_valid (cmt_we),
        .push_data  (cmt_old_prd),
        .restore    (restore),
        .peek_data  (peek_flat),
        .free_cnt   (free_cnt)
    );

`ifdef REG_MNG_BUSY_TABLE_EN
    logic [PHYS_REGS-1:0] rdy_q, rdy_d;
    logic [PHYS_REGS-1:0] wb_hit;

    always_comb begin
        wb_hit = '0;
        for (int k = 0; k < RENAME_W; k++) begin
            if (wb_valid[k]) wb_hit[wb_prd[k*PW +: PW]] = 1'b1;
        end
    end

    // Clears from allocation are applied after writeback sets, so allocation wins.
    always_comb begin
        rdy_d = rdy_q | wb_hit;
        if (state_q == RECOVER) begin
            rdy_d = '1;
        end else if (accept) begin
            for (int k = 0; k < RENAME_W; k++) begin
                if (we_eff[k]) rdy_d[prd_a[k]] = 1'b0;
            end
        end
        rdy_d[0] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_q <= '1;
        else        rdy_q <= rdy_d;
    end

    always_comb begin
        ren_rs1_rdy = '0;
        ren_rs2_rdy = '0;
        for (int k = 0; k < RENAME_W; k++) begin
            ren_rs1_rdy[k] = rdy_q[prs1_a[k]] | wb_hit[prs1_a[k]];
            ren_rs2_rdy[k] = rdy_q[prs2_a[k]] | wb_hit[prs2_a[k]];
            for (int j = 0; j < k; j++) begin
                if (we_eff[j] && (rd_a[j] == rs1_a[k])) ren_rs1_rdy[k] = 1'b0;
                if (we_eff[j] && (rd_a[j] == rs2_a[k])) ren_rs2_rdy[k] = 1'b0;
            end
            if (rs1_a[k] == '0) ren_rs1_rdy[k] = 1'b1;
            if (rs2_a[k] == '0) ren_rs2_rdy[k] = 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_reg_rename_mng.sv
// Directed self-checking bench for reg_rename_mng (default 32/64/2 config);
// ready-table checks build only with REG_MNG_BUSY_TABLE_EN.
module tb_reg_rename_mng;

    localparam int RW = 2;
    localparam int AW = 5;
    localparam int PW = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [RW-1:0]     ren_valid, ren_rd_we, cmt_valid, cmt_rd_we;
    logic              ren_ready, flush, busy;
    logic [RW*AW-1:0]  ren_rs1, ren_rs2, ren_rd, cmt_rd;
    logic [RW*PW-1:0]  ren_prs1, ren_prs2, ren_prd, ren_old_prd;
    logic [RW*PW-1:0]  cmt_prd, cmt_old_prd;
`ifdef REG_MNG_BUSY_TABLE_EN
    logic [RW-1:0]     wb_valid, ren_rs1_rdy, ren_rs2_rdy;
    logic [RW*PW-1:0]  wb_prd;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    reg_rename_mng dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ren_valid   (ren_valid),
        .ren_ready   (ren_ready),
        .ren_rs1     (ren_rs1),
        .ren_rs2     (ren_rs2),
        .ren_rd      (ren_rd),
        .ren_rd_we   (ren_rd_we),
        .ren_prs1    (ren_prs1),
        .ren_prs2    (ren_prs2),
        .ren_prd     (ren_prd),
        .ren_old_prd (ren_old_prd),
        .cmt_valid   (cmt_valid),
        .cmt_rd_we   (cmt_rd_we),
        .cmt_rd      (cmt_rd),
        .cmt_prd     (cmt_prd),
        .cmt_old_prd (cmt_old_prd),
        .flush       (flush),
`ifdef REG_MNG_BUSY_TABLE_EN
        .wb_valid    (wb_valid),
        .wb_prd      (wb_prd),
        .ren_rs1_rdy (ren_rs1_rdy),
        .ren_rs2_rdy (ren_rs2_rdy),
`endif
        .busy        (busy)
    );

    typedef struct {
        logic [1:0] v;
        logic [1:0] we;
        int rs1_0, rs1_1, rs2_0, rs2_1, rd_0, rd_1;
        int e_prs1_0, e_prs1_1, e_prs2_0, e_prs2_1;
        int e_prd_0, e_prd_1, e_old_0, e_old_1;
        int e_rdy;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_lane(input string tag, input int k, input int e1,
                            input int e2, input int ep, input int eo);
        chk($sformatf("%s l%0d prs1", tag, k), int'(ren_prs1[k*PW +: PW]), e1);
        chk($sformatf("%s l%0d prs2", tag, k), int'(ren_prs2[k*PW +: PW]), e2);
        chk($sformatf("%s l%0d prd", tag, k), int'(ren_prd[k*PW +: PW]), ep);
        chk($sformatf("%s l%0d old_prd", tag, k), int'(ren_old_prd[k*PW +: PW]), eo);
    endtask

    task automatic drive_ren(input logic [1:0] v, input logic [1:0] we,
                             input int r10, input int r11, input int r20,
                             input int r21, input int d0, input int d1);
        ren_valid = v;
        ren_rd_we = we;
        ren_rs1   = {5'(r11), 5'(r10)};
        ren_rs2   = {5'(r21), 5'(r20)};
        ren_rd    = {5'(d1), 5'(d0)};
    endtask

    task automatic drive_cmt(input logic [1:0] cv, input logic [1:0] cwe,
                             input int d0, input int d1, input int p0,
                             input int p1, input int o0, input int o1);
        cmt_valid   = cv;
        cmt_rd_we   = cwe;
        cmt_rd      = {5'(d1), 5'(d0)};
        cmt_prd     = {6'(p1), 6'(p0)};
        cmt_old_prd = {6'(o1), 6'(o0)};
    endtask

    task automatic idle_all();
        drive_ren(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        drive_cmt(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        flush = 1'b0;
`ifdef REG_MNG_BUSY_TABLE_EN
        wb_valid = '0;
        wb_prd   = '0;
`endif
    endtask

    task automatic reset_dut();
        idle_all();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // v, we, rs1(l0,l1), rs2(l0,l1), rd(l0,l1), prs1, prs2, prd, old_prd, ready
        tbl[0] = '{2'b01, 2'b01, 5, 0, 0, 0, 3, 0,   5, 0,  0, 0,  32, 0,  3, 0,  1};
        tbl[1] = '{2'b11, 2'b11, 3, 7, 5, 3, 7, 7,   32, 33, 5, 32, 33, 34, 7, 33, 1};
        tbl[2] = '{2'b11, 2'b01, 0, 3, 7, 0, 0, 3,   0, 32, 34, 0,  0, 0,  0, 32, 1};
        tbl[3] = '{2'b11, 2'b11, 9, 9, 9, 10, 9, 10, 9, 35, 9, 10,  35, 36, 9, 10, 1};
        tbl[4] = '{2'b11, 2'b10, 9, 7, 10, 0, 0, 9,  35, 34, 36, 0, 0, 37, 0, 35, 1};
        tbl[5] = '{2'b11, 2'b11, 9, 12, 3, 9, 12, 12, 37, 38, 32, 37, 38, 39, 12, 38, 1};
        tbl[6] = '{2'b11, 2'b00, 12, 9, 7, 10, 0, 12, 39, 37, 34, 36, 0, 0, 0, 39, 1};

        reset_dut();
        #1;
        chk("reset ready", int'(ren_ready), 1);
        chk("reset busy", int'(busy), 0);
        chk("reset prd", int'(ren_prd), 0);
        chk("reset prs1", int'(ren_prs1), 0);
        chk("reset old_prd", int'(ren_old_prd), 0);
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            drive_ren(tbl[i].v, tbl[i].we, tbl[i].rs1_0, tbl[i].rs1_1,
                      tbl[i].rs2_0, tbl[i].rs2_1, tbl[i].rd_0, tbl[i].rd_1);
            #1;
            chk($sformatf("vec%0d ready", i), int'(ren_ready), tbl[i].e_rdy);
            chk_lane($sformatf("vec%0d", i), 0, tbl[i].e_prs1_0, tbl[i].e_prs2_0,
                     tbl[i].e_prd_0, tbl[i].e_old_0);
            chk_lane($sformatf("vec%0d", i), 1, tbl[i].e_prs1_1, tbl[i].e_prs2_1,
                     tbl[i].e_prd_1, tbl[i].e_old_1);
            @(negedge clk);
        end

        // Drain the remaining 24 entries, then free one at a time across the wrap.
        for (int i = 0; i < 12; i++) begin
            drive_ren(2'b11, 2'b11, 0, 0, 0, 0, 1, 2);
            #1;
            chk($sformatf("drain%0d ready", i), int'(ren_ready), 1);
            chk_lane($sformatf("drain%0d", i), 0, 0, 0, 40 + 2*i, (i == 0) ? 1 : 38 + 2*i);
            chk_lane($sformatf("drain%0d", i), 1, 0, 0, 41 + 2*i, (i == 0) ? 2 : 39 + 2*i);
            @(negedge clk);
        end
        #1;
        chk("empty ready", int'(ren_ready), 0);
        @(negedge clk);
        drive_ren(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        drive_cmt(2'b01, 2'b01, 7, 0, 34, 0, 7, 0);
        #1;
        chk("empty cmt ready", int'(ren_ready), 0);
        @(negedge clk);
        drive_cmt(2'b01, 2'b01, 9, 0, 37, 0, 9, 0);
        #1;
        chk("one free ready", int'(ren_ready), 0);
        @(negedge clk);
        drive_cmt(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        drive_ren(2'b11, 2'b11, 0, 0, 0, 0, 1, 2);
        #1;
        chk("two free ready", int'(ren_ready), 1);
        chk_lane("wrap", 0, 0, 0, 7, 62);
        chk_lane("wrap", 1, 0, 0, 9, 63);
        @(negedge clk);
        #1;
        chk("refill empty ready", int'(ren_ready), 0);
        @(negedge clk);

        // Flush recovery.
        reset_dut();
        drive_ren(2'b01, 2'b01, 0, 0, 0, 0, 4, 0);
        #1;
        chk_lane("fl a", 0, 0, 0, 32, 4);
        @(negedge clk);
        drive_ren(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        drive_cmt(2'b01, 2'b01, 4, 0, 32, 0, 4, 0);
        @(negedge clk);
        drive_cmt(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        drive_ren(2'b01, 2'b01, 4, 0, 0, 0, 4, 0);
        #1;
        chk_lane("fl b", 0, 32, 0, 33, 32);
        @(negedge clk);
        flush = 1'b1;
        drive_ren(2'b01, 2'b01, 0, 0, 0, 0, 5, 0);
        #1;
        chk("flush ready", int'(ren_ready), 0);
        chk("flush busy", int'(busy), 0);
        @(negedge clk);
        flush = 1'b0;
        drive_ren(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        #1;
        chk("recover busy", int'(busy), 1);
        chk("recover ready", int'(ren_ready), 0);
        @(negedge clk);
        drive_ren(2'b01, 2'b01, 4, 0, 0, 0, 5, 0);
        #1;
        chk("post recover busy", int'(busy), 0);
        chk("post recover ready", int'(ren_ready), 1);
        chk_lane("fl c", 0, 32, 0, 33, 5);
        @(negedge clk);
        flush = 1'b1;
        drive_ren(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        drive_cmt(2'b01, 2'b01, 5, 0, 33, 0, 5, 0);
        @(negedge clk);
        drive_cmt(2'b01, 2'b01, 5, 0, 50, 0, 20, 0);
        #1;
        chk("recover2 busy", int'(busy), 1);
        @(negedge clk);
        flush = 1'b0;
        drive_cmt(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        drive_ren(2'b01, 2'b01, 5, 0, 0, 0, 6, 0);
        #1;
        chk("flush in recover ignored", int'(busy), 0);
        chk_lane("fl d", 0, 33, 0, 34, 6);
        @(negedge clk);
        flush = 1'b1;
        drive_ren(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        drive_ren(2'b01, 2'b01, 5, 0, 6, 0, 7, 0);
        #1;
        chk_lane("fl e", 0, 33, 6, 34, 7);
        @(negedge clk);

        // Reset in the middle of RECOVER.
        flush = 1'b1;
        drive_ren(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        flush = 1'b0;
        drive_ren(2'b01, 2'b01, 5, 0, 0, 0, 8, 0);
        #1;
        chk("pre-reset busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid-recover reset busy", int'(busy), 0);
        chk("mid-recover reset ready", int'(ren_ready), 1);
        chk_lane("rst mid", 0, 5, 0, 32, 8);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef REG_MNG_BUSY_TABLE_EN
        reset_dut();
        drive_ren(2'b01, 2'b01, 0, 0, 0, 0, 3, 0);
        @(negedge clk);
        drive_ren(2'b11, 2'b11, 3, 8, 3, 0, 8, 9);
        #1;
        chk("rdy alloc rs1", int'(ren_rs1_rdy[0]), 0);
        chk("rdy alloc rs2", int'(ren_rs2_rdy[0]), 0);
        chk("rdy bypass rs1", int'(ren_rs1_rdy[1]), 0);
        chk("rdy zero rs2", int'(ren_rs2_rdy[1]), 1);
        @(negedge clk);
        drive_ren(2'b01, 2'b00, 3, 0, 9, 0, 0, 0);
        wb_valid = 2'b01;
        wb_prd   = {6'd0, 6'd32};
        #1;
        chk("rdy wb bypass", int'(ren_rs1_rdy[0]), 1);
        chk("rdy other", int'(ren_rs2_rdy[0]), 0);
        @(negedge clk);
        wb_valid = 2'b00;
        #1;
        chk("rdy after wb", int'(ren_rs1_rdy[0]), 1);
        @(negedge clk);
        drive_ren(2'b01, 2'b01, 0, 0, 0, 0, 10, 0);
        wb_valid = 2'b01;
        wb_prd   = {6'd0, 6'd35};
        @(negedge clk);
        wb_valid = 2'b00;
        drive_ren(2'b01, 2'b00, 10, 0, 0, 0, 0, 0);
        #1;
        chk("rdy alloc wins prs", int'(ren_prs1[5:0]), 35);
        chk("rdy alloc wins", int'(ren_rs1_rdy[0]), 0);
        @(negedge clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
